// File: rtl/alu_pkg.sv
// Shared ALU control codes, funct fields, ALUOp encodings and issue FSM state type.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_CTRL_W = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct decoder producing the ALU control code and an illegal flag.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int CTRL_W = 4
) (
  input  logic [1:0]        aluop_i,
  input  logic [5:0]        funct_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              illegal_o
);

  always_comb begin
    ctrl_o    = CTRL_W'(ALU_ADD);
    illegal_o = 1'b0;
    case (aluop_i)
      ALUOP_ADD: ctrl_o = CTRL_W'(ALU_ADD);
      ALUOP_SUB: ctrl_o = CTRL_W'(ALU_SUB);
      ALUOP_OR:  ctrl_o = CTRL_W'(ALU_OR);
      default: begin
        case (funct_i)
          FUNCT_ADD: ctrl_o = CTRL_W'(ALU_ADD);
          FUNCT_SUB: ctrl_o = CTRL_W'(ALU_SUB);
          FUNCT_AND: ctrl_o = CTRL_W'(ALU_AND);
          FUNCT_OR:  ctrl_o = CTRL_W'(ALU_OR);
          FUNCT_SLT: ctrl_o = CTRL_W'(ALU_SLT);
          FUNCT_NOR: ctrl_o = CTRL_W'(ALU_NOR);
          default: begin
            // Unknown funct still runs the ALU as ADD; the response is zeroed later.
            ctrl_o    = CTRL_W'(ALU_ADD);
            illegal_o = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded op to the combinational ALU and holds the captured response.
// Optional ALU_STICKY_OVF_EN adds a sticky overflow flag with a clear input.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        aluop_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  input  logic              alu_cout_i,
  input  logic              alu_ovf_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              cout_o,
  output logic              ovf_o,
  output logic              illegal_o,
`ifdef ALU_STICKY_OVF_EN
  output logic              ovf_sticky_o,
  input  logic              clr_sticky_i,
`endif
  output logic [1:0]        state_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready, and a held response stays stable until transferred.

  alu_state_t        state_q;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              illegal_q;
  logic              accept;
  logic              capture;

  alu_op_decode #(.CTRL_W(CTRL_W)) u_decode (
    .aluop_i   (aluop_i),
    .funct_i   (funct_i),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  assign in_ready_o  = ~rst_i & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready_i));
  assign accept      = in_valid_i & in_ready_o;
  assign capture     = (state_q == ST_EXEC);
  assign out_valid_o = (state_q == ST_DONE);
  assign state_o     = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      alu_src1_o <= '0;
      alu_src2_o <= '0;
      alu_ctrl_o <= '0;
      illegal_q  <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      ovf_o      <= 1'b0;
      illegal_o  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            alu_src1_o <= src1_i;
            alu_src2_o <= src2_i;
            alu_ctrl_o <= dec_ctrl;
            illegal_q  <= dec_illegal;
            state_q    <= ST_EXEC;
          end else if (state_q == ST_DONE && out_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          result_o  <= illegal_q ? '0 : alu_result_i;
          zero_o    <= ~illegal_q & alu_zero_i;
          cout_o    <= ~illegal_q & alu_cout_i;
          ovf_o     <= ~illegal_q & alu_ovf_i;
          illegal_o <= illegal_q;
          state_q   <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_STICKY_OVF_EN
  // Set has priority over a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_sticky_o <= 1'b0;
    end else if (capture && !illegal_q && alu_ovf_i) begin
      ovf_sticky_o <= 1'b1;
    end else if (clr_sticky_i) begin
      ovf_sticky_o <= 1'b0;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a response scoreboard.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [1:0]    aluop_i;
  logic [5:0]    funct_i;
  logic [W-1:0]  src1_i, src2_i;
  logic [W-1:0]  alu_src1_o, alu_src2_o;
  logic [3:0]    alu_ctrl_o;
  logic [W-1:0]  alu_result_i;
  logic          alu_zero_i, alu_cout_i, alu_ovf_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [W-1:0]  result_o;
  logic          zero_o, cout_o, ovf_o, illegal_o;
  logic [1:0]    state_o;
`ifdef ALU_STICKY_OVF_EN
  logic          ovf_sticky_o;
  logic          clr_sticky_i;
`endif

  int total = 0;
  int bad   = 0;
  logic [35:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(W), .CTRL_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .aluop_i(aluop_i), .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .alu_cout_i(alu_cout_i), .alu_ovf_i(alu_ovf_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .zero_o(zero_o), .cout_o(cout_o), .ovf_o(ovf_o),
    .illegal_o(illegal_o),
`ifdef ALU_STICKY_OVF_EN
    .ovf_sticky_o(ovf_sticky_o), .clr_sticky_i(clr_sticky_i),
`endif
    .state_o(state_o)
  );

  // behavioural ALU
  always_comb begin
    logic [W:0] s;
    s            = '0;
    alu_result_i = '0;
    alu_cout_i   = 1'b0;
    alu_ovf_i    = 1'b0;
    case (alu_ctrl_o)
      4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
      4'b0001: alu_result_i = alu_src1_o | alu_src2_o;
      4'b0010: begin
        s = {1'b0, alu_src1_o} + {1'b0, alu_src2_o};
        alu_result_i = s[W-1:0];
        alu_cout_i   = s[W];
        alu_ovf_i    = (alu_src1_o[W-1] == alu_src2_o[W-1]) && (s[W-1] != alu_src1_o[W-1]);
      end
      4'b0110: begin
        s = {1'b0, alu_src1_o} + {1'b0, ~alu_src2_o} + 33'd1;
        alu_result_i = s[W-1:0];
        alu_cout_i   = s[W];
        alu_ovf_i    = (alu_src1_o[W-1] != alu_src2_o[W-1]) && (s[W-1] != alu_src1_o[W-1]);
      end
      4'b0111: alu_result_i = ($signed(alu_src1_o) < $signed(alu_src2_o)) ? 32'd1 : 32'd0;
      4'b1100: alu_result_i = ~(alu_src1_o | alu_src2_o);
      default: alu_result_i = '0;
    endcase
    alu_zero_i = (alu_result_i == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: present an op and hold it until accepted; returns #1 after the accept edge
  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [35:0] exp, input bit push);
    int n;
    @(posedge clk); #1;
    aluop_i = op; funct_i = fn; src1_i = a; src2_i = b; in_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready_o stuck 0 expected 1");
      in_valid_i = 1'b0;
    end else begin
      if (push) exp_q.push_back(exp);
      @(posedge clk); #1;
      in_valid_i = 1'b0;
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_o) begin
      total++; bad++;
      $display("FAIL valid_timeout: out_valid_o stuck 0 expected 1");
    end
  endtask

  // scoreboard monitor: pops on each observed response handshake
  always @(negedge clk) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected: got 0x%0h expected none",
                 {illegal_o, ovf_o, cout_o, zero_o, result_o});
      end else begin
        check("resp", 64'({illegal_o, ovf_o, cout_o, zero_o, result_o}), 64'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [35:0] rsp(input logic ill, input logic ov, input logic co,
                                      input logic z, input logic [W-1:0] r);
    return {ill, ov, co, z, r};
  endfunction

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    aluop_i = 2'b00; funct_i = 6'd0; src1_i = '0; src2_i = '0;
`ifdef ALU_STICKY_OVF_EN
    clr_sticky_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready_o), 64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_state", 64'(state_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready_o), 64'd1);

    // R-type ADD, latency check
    issue(ALUOP_RTYPE, 6'b100000, 32'd7, 32'd5, rsp(0, 0, 0, 0, 32'd12), 1);
    check("add_ctrl_exec", 64'(alu_ctrl_o), 64'h2);
    check("add_src1_exec", 64'(alu_src1_o), 64'd7);
    check("add_valid_n1", 64'(out_valid_o), 64'd0);
    @(posedge clk); #1;
    check("add_valid_n2", 64'(out_valid_o), 64'd1);

    issue(ALUOP_SUB, 6'b000000, 32'h1234, 32'h1234, rsp(0, 0, 1, 1, 32'd0), 1);
    check("sub_ctrl_exec", 64'(alu_ctrl_o), 64'h6);
    issue(ALUOP_ADD, 6'b000000, 32'h7FFFFFFF, 32'd1, rsp(0, 1, 0, 0, 32'h80000000), 1);
    issue(ALUOP_OR, 6'b000000, 32'hF0, 32'h0F, rsp(0, 0, 0, 0, 32'hFF), 1);
    check("ori_ctrl_exec", 64'(alu_ctrl_o), 64'h1);
`ifdef ALU_STICKY_OVF_EN
    @(negedge clk);
    check("sticky_held", 64'(ovf_sticky_o), 64'd1);
    @(posedge clk); #1;
    clr_sticky_i = 1'b1;
    @(posedge clk); #1;
    clr_sticky_i = 1'b0;
    check("sticky_cleared", 64'(ovf_sticky_o), 64'd0);
`endif
    issue(ALUOP_RTYPE, 6'b100100, 32'hFF00, 32'h0FF0, rsp(0, 0, 0, 0, 32'h0F00), 1);
    issue(ALUOP_RTYPE, 6'b100101, 32'h1000, 32'h0001, rsp(0, 0, 0, 0, 32'h1001), 1);
    issue(ALUOP_RTYPE, 6'b101010, 32'd3, 32'd5, rsp(0, 0, 0, 0, 32'd1), 1);
    check("slt_ctrl_exec", 64'(alu_ctrl_o), 64'h7);
    issue(ALUOP_RTYPE, 6'b100111, 32'd0, 32'd0, rsp(0, 0, 0, 0, 32'hFFFFFFFF), 1);
    check("nor_ctrl_exec", 64'(alu_ctrl_o), 64'hC);
    issue(ALUOP_RTYPE, 6'b100010, 32'd10, 32'd3, rsp(0, 0, 1, 0, 32'd7), 1);

    // illegal funct: ALU runs as ADD but response is zeroed
    issue(ALUOP_RTYPE, 6'b111111, 32'hFFFFFFFF, 32'd1, rsp(1, 0, 0, 0, 32'd0), 1);
    check("ill_ctrl_exec", 64'(alu_ctrl_o), 64'h2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ill_back_idle", 64'(state_o), 64'(ST_IDLE));

    // backpressure then back-to-back accept
    out_ready_i = 1'b0;
    issue(ALUOP_ADD, 6'b000000, 32'd1, 32'd2, rsp(0, 0, 0, 0, 32'd3), 1);
    @(negedge clk);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready_o), 64'd0);
      check("bp_result", 64'({out_valid_o, result_o}), {31'd0, 1'b1, 32'd3});
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    issue(ALUOP_SUB, 6'b000000, 32'd9, 32'd4, rsp(0, 0, 1, 0, 32'd5), 1);
    check("b2b_exec", 64'(state_o), 64'(ST_EXEC));

    // reset mid-EXEC drops the op
    @(negedge clk);
    wait_valid();
    issue(ALUOP_ADD, 6'b000000, 32'd100, 32'd200, 36'd0, 0);
    rst_i = 1'b1;
    #1;
    check("rstx_out_valid", 64'(out_valid_o), 64'd0);
    check("rstx_in_ready", 64'(in_ready_o), 64'd0);
    check("rstx_outs", 64'({alu_ctrl_o, illegal_o, result_o}), 64'd0);
    check("rstx_src1", 64'(alu_src1_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    issue(ALUOP_RTYPE, 6'b101010, 32'hFFFFFFFF, 32'd1, rsp(0, 0, 0, 0, 32'd1), 1);

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d responses outstanding expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
